// File: rtl/fifo_pkg.sv
// Shared types and constants for the write-side word packer of the 140-bit CDC FIFO.
// A word is {beat count, channel, payload}.
package fifo_pkg;

  localparam int WORD_W    = 140;
  localparam int BEAT_W    = 16;
  localparam int BEATS     = 8;
  localparam int CHAN_W    = 8;
  localparam int CNTF_W    = 4;
  localparam int CNT_LSB   = 136;
  localparam int CHAN_LSB  = 128;
  localparam int PAYLOAD_W = BEATS * BEAT_W;

  typedef struct packed {
    logic [CNTF_W-1:0]    cnt;
    logic [CHAN_W-1:0]    chan;
    logic [PAYLOAD_W-1:0] payload;
  } fifo_word_t;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_FILL = 1'b1
  } acc_state_e;

endpackage

// File: rtl/fifo_out_reg.sv
// One-entry holding register between the packer and the FIFO write port.
// It writes whenever it holds a word and the FIFO is not full, and it can reload on the same edge.
module fifo_out_reg
  import fifo_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              fifo_full_i,
  output logic              out_free_o,
  output logic              fifo_w_enable_o,
  output logic [WORD_W-1:0] data_o
);

  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_word_q, out_word_d;
  logic              write;

  assign write           = out_valid_q && !fifo_full_i;
  assign fifo_w_enable_o = write;
  assign out_free_o      = !out_valid_q || write;
  assign data_o          = out_valid_q ? out_word_q : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    if (load_i) begin
      out_valid_d = 1'b1;
      out_word_d  = word_i;
    end else if (write) begin
      out_valid_d = 1'b0;
      out_word_d  = '0;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Packs 16-bit beats into 140-bit words and closes a word on the 8th beat, on din_last or on idle timeout.
// Completed words are handed to fifo_out_reg, which drives the FIFO write port.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [BEAT_W-1:0] din,
  input  logic [CHAN_W-1:0] din_chan,
  input  logic              din_valid,
  input  logic              din_last,
  output logic              din_ready,
  input  logic              fifo_full,
  output logic              fifo_w_enable,
  output logic [WORD_W-1:0] data_to_fifo,
  output logic              err_chan,
  output logic [CNT_W-1:0]  words_written
);

  localparam int IDLE_W = $clog2(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);
  localparam logic [CNTF_W-1:0] FULL_CNT = CNTF_W'(BEATS);

  acc_state_e           state_q, state_d;
  logic [CNTF_W-1:0]    cnt_q, cnt_d;
  logic [CHAN_W-1:0]    chan_q, chan_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [IDLE_W-1:0]    idle_q, idle_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     words_q, words_d;

  logic                 out_free;
  logic                 beat_accept;
  logic                 load;
  fifo_word_t           load_word;
  logic [CNTF_W-1:0]    cnt_inc;
  logic [CHAN_W-1:0]    acc_chan;
  logic [PAYLOAD_W-1:0] acc_payload;

  // A stall exists only while the held word is blocked, so ready equals out_free.
  assign din_ready   = out_free;
  assign beat_accept = din_valid && din_ready;
  assign cnt_inc     = cnt_q + 1'b1;
  assign acc_chan    = (state_q == ACC_IDLE) ? din_chan : chan_q;

  always_comb begin
    acc_payload = payload_q;
    for (int k = 0; k < BEATS; k++) begin
      if (cnt_q == CNTF_W'(k)) acc_payload[k*BEAT_W +: BEAT_W] = din;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    chan_d    = chan_q;
    payload_d = payload_q;
    idle_d    = idle_q;
    err_d     = err_q;
    load      = 1'b0;
    load_word = '0;
    if (beat_accept) begin
      if (state_q == ACC_FILL && din_chan != chan_q) err_d = 1'b1;
      idle_d = '0;
      if (cnt_inc == FULL_CNT || din_last) begin
        load      = 1'b1;
        load_word = '{cnt: cnt_inc, chan: acc_chan, payload: acc_payload};
        state_d   = ACC_IDLE;
        cnt_d     = '0;
        payload_d = '0;
      end else begin
        state_d   = ACC_FILL;
        cnt_d     = cnt_inc;
        chan_d    = acc_chan;
        payload_d = acc_payload;
      end
    end else if (state_q == ACC_FILL) begin
      if (idle_q != IDLE_MAX) begin
        idle_d = idle_q + 1'b1;
      end else if (out_free) begin
        load      = 1'b1;
        load_word = '{cnt: cnt_q, chan: chan_q, payload: payload_q};
        state_d   = ACC_IDLE;
        cnt_d     = '0;
        payload_d = '0;
        idle_d    = '0;
      end
    end
  end

  assign words_d = (fifo_w_enable && words_q != '1) ? words_q + 1'b1 : words_q;

  // NOTE: the payload is a plain register bank rather than a RAM, so it resets with the rest.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACC_IDLE;
      cnt_q     <= '0;
      chan_q    <= '0;
      payload_q <= '0;
      idle_q    <= '0;
      err_q     <= 1'b0;
      words_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      chan_q    <= chan_d;
      payload_q <= payload_d;
      idle_q    <= idle_d;
      err_q     <= err_d;
      words_q   <= words_d;
    end
  end

  assign err_chan      = err_q;
  assign words_written = words_q;

  fifo_out_reg u_out_reg (
    .clk_in          (clk_in),
    .rst_n           (rst_n),
    .load_i          (load),
    .word_i          (load_word),
    .fifo_full_i     (fifo_full),
    .out_free_o      (out_free),
    .fifo_w_enable_o (fifo_w_enable),
    .data_o          (data_to_fifo)
  );

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer: a queue-based word model compared every cycle,
// plus directed scenarios pinned by hand-computed literal words.
module tb_fifo_word_packer;

  localparam int TIMEOUT = 64;

  logic         clk_in = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  din = '0;
  logic [7:0]   din_chan = '0;
  logic         din_valid = 1'b0;
  logic         din_last = 1'b0;
  logic         din_ready;
  logic         fifo_full = 1'b0;
  logic         fifo_w_enable;
  logic [139:0] data_to_fifo;
  logic         err_chan;
  logic [15:0]  words_written;

  int n_cmp = 0;
  int n_fail = 0;

  fifo_word_packer #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk_in        (clk_in),
    .rst_n         (rst_n),
    .din           (din),
    .din_chan      (din_chan),
    .din_valid     (din_valid),
    .din_last      (din_last),
    .din_ready     (din_ready),
    .fifo_full     (fifo_full),
    .fifo_w_enable (fifo_w_enable),
    .data_to_fifo  (data_to_fifo),
    .err_chan      (err_chan),
    .words_written (words_written)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [139:0] act, input logic [139:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0]  m_beats[$];
  logic [7:0]   m_chan;
  int           m_idle;
  bit           m_out_valid;
  logic [139:0] m_out_word;
  bit           m_err;
  int           m_words;

  function automatic logic [139:0] pack_word(input logic [15:0] b[$], input logic [7:0] c);
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < b.size(); i++) p[i*16 +: 16] = b[i];
    return {4'(b.size()), c, p};
  endfunction

  task automatic model_reset();
    m_beats.delete();
    m_chan = '0;
    m_idle = 0;
    m_out_valid = 0;
    m_out_word = '0;
    m_err = 0;
    m_words = 0;
  endtask

  // Compare one unit before each rising edge, then advance the model across that edge.
  initial begin
    bit m_ready, m_wen, acc, load;
    logic [139:0] w;
    model_reset();
    forever begin
      @(negedge clk_in);
      #4;
      if (!rst_n) model_reset();
      m_ready = !(m_out_valid && fifo_full);
      m_wen   = m_out_valid && !fifo_full;
      check("din_ready", din_ready, m_ready);
      check("fifo_w_enable", fifo_w_enable, m_wen);
      check("data_to_fifo", data_to_fifo, m_out_valid ? m_out_word : 140'h0);
      check("err_chan", err_chan, m_err);
      check("words_written", words_written, m_words);
      if (rst_n) begin
        acc = din_valid && m_ready;
        load = 0;
        w = '0;
        if (acc) begin
          if (m_beats.size() == 0) m_chan = din_chan;
          else if (din_chan != m_chan) m_err = 1;
          m_beats.push_back(din);
          m_idle = 0;
          if (m_beats.size() == 8 || din_last) begin
            load = 1;
            w = pack_word(m_beats, m_chan);
            m_beats.delete();
          end
        end else if (m_beats.size() > 0) begin
          if (m_idle == TIMEOUT - 1 && (!m_out_valid || m_wen)) begin
            load = 1;
            w = pack_word(m_beats, m_chan);
            m_beats.delete();
            m_idle = 0;
          end else if (m_idle < TIMEOUT - 1) begin
            m_idle++;
          end
        end
        if (load) begin
          m_out_valid = 1;
          m_out_word = w;
        end else if (m_wen) begin
          m_out_valid = 0;
        end
        if (m_wen && m_words < 65535) m_words++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_beat(input logic [15:0] b, input logic [7:0] c, input logic l);
    @(negedge clk_in);
    din = b;
    din_chan = c;
    din_valid = 1'b1;
    din_last = l;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_in);
      din_valid = 1'b0;
      din_last = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [139:0] exp_w;

    // Reset state
    #1;
    check("rst_wen", fifo_w_enable, 1'b0);
    check("rst_data", data_to_fifo, 140'h0);
    check("rst_words", words_written, 16'h0);
    repeat (2) @(negedge clk_in);
    #2 rst_n = 1'b1;
    #1 check("rst_ready", din_ready, 1'b1);

    // 1: full 8-beat word
    for (int k = 1; k <= 8; k++) drive_beat(16'(k), 8'h5A, 1'b0);
    idle(1);
    #1;
    exp_w = {4'h8, 8'h5A, 128'h0008_0007_0006_0005_0004_0003_0002_0001};
    check("t1_wen", fifo_w_enable, 1'b1);
    check("t1_word", data_to_fifo, exp_w);
    idle(1);
    #1 check("t1_count", words_written, 16'd1);

    // 2: short packet closed by din_last
    drive_beat(16'h00A1, 8'h03, 1'b0);
    drive_beat(16'h00A2, 8'h03, 1'b0);
    drive_beat(16'h00A3, 8'h03, 1'b1);
    idle(1);
    #1;
    exp_w = {4'h3, 8'h03, 80'h0, 48'h00A3_00A2_00A1};
    check("t2_word", data_to_fifo, exp_w);
    idle(2);

    // 3: backpressure holds a 1-beat word
    drive_beat(16'hBEEF, 8'h22, 1'b1);
    fifo_full = 1'b1;
    idle(1);
    #1;
    check("t3_ready_low", din_ready, 1'b0);
    check("t3_wen_low", fifo_w_enable, 1'b0);
    idle(9);
    #1;
    exp_w = {4'h1, 8'h22, 112'h0, 16'hBEEF};
    check("t3_hold_word", data_to_fifo, exp_w);
    @(negedge clk_in);
    fifo_full = 1'b0;
    #1;
    check("t3_wen_release", fifo_w_enable, 1'b1);
    check("t3_ready_release", din_ready, 1'b1);
    idle(2);

    // 4a: idle timeout closes a 2-beat word on the 64th idle cycle
    drive_beat(16'h1111, 8'h07, 1'b0);
    drive_beat(16'h2222, 8'h07, 1'b0);
    idle(TIMEOUT);
    #1 check("t4_no_early_write", fifo_w_enable, 1'b0);
    idle(1);
    #1;
    exp_w = {4'h2, 8'h07, 96'h0, 32'h2222_1111};
    check("t4_timeout_wen", fifo_w_enable, 1'b1);
    check("t4_timeout_word", data_to_fifo, exp_w);
    idle(2);

    // 4b: beat in the expiry cycle is appended instead of closing
    drive_beat(16'h3333, 8'h07, 1'b0);
    drive_beat(16'h4444, 8'h07, 1'b0);
    idle(TIMEOUT - 1);
    drive_beat(16'h5555, 8'h07, 1'b1);
    idle(1);
    #1;
    exp_w = {4'h3, 8'h07, 80'h0, 48'h5555_4444_3333};
    check("t4_expiry_word", data_to_fifo, exp_w);
    idle(2);

    // 5: channel change mid-word
    drive_beat(16'h000A, 8'h10, 1'b0);
    drive_beat(16'h000B, 8'h10, 1'b0);
    #1 check("t5_err_before", err_chan, 1'b0);
    drive_beat(16'h000C, 8'h11, 1'b1);
    idle(1);
    #1;
    exp_w = {4'h3, 8'h10, 80'h0, 48'h000C_000B_000A};
    check("t5_err_set", err_chan, 1'b1);
    check("t5_word_chan", data_to_fifo, exp_w);
    idle(5);
    #1 check("t5_err_sticky", err_chan, 1'b1);

    // 6: reset mid-word discards the partial word
    for (int k = 1; k <= 5; k++) drive_beat(16'h0E00 + 16'(k), 8'h33, 1'b0);
    @(negedge clk_in);
    din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_wen", fifo_w_enable, 1'b0);
    check("t6_data", data_to_fifo, 140'h0);
    check("t6_err", err_chan, 1'b0);
    check("t6_words", words_written, 16'h0);
    @(negedge clk_in);
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) drive_beat(16'hC000 + 16'(k), 8'h44, 1'b0);
    idle(1);
    #1;
    exp_w = {4'h8, 8'h44, 128'hC008_C007_C006_C005_C004_C003_C002_C001};
    check("t6_clean_word", data_to_fifo, exp_w);
    idle(1);
    #1 check("t6_count", words_written, 16'd1);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
Write-side packer feeding the clk_in side of the 140-bit dual-clock CDC FIFO. It accumulates 16-bit input beats into a single 140-bit word: 4-bit beat count, 8-bit channel, and 128-bit payload. It closes a word on the 8th beat, on din_last, or on an idle timeout. It then drives the FIFO write port, honouring fifo_full, through a one-entry output register.

Parameters:
BEAT_W, 16, input beat width
BEATS, 8, beats per word
CHAN_W, 8, channel id width
TIMEOUT, 64, idle cycles before a partial word is force-closed (>=2)
CNT_W, 16, width of the written-word counter

Ports:
clk_in  in  1  write-domain clock
rst_n  in  1  reset, asynchronous, active-low
din  in  16  input beat
din_chan  in  8  channel id, sampled on the first beat of a word
din_valid  in  1  beat valid
din_last  in  1  final beat of packet
din_ready  out  1  beat accepted when din_valid && din_ready
fifo_full  in  1  full flag from the FIFO write side
fifo_w_enable  out  1  FIFO write strobe
data_to_fifo  out  140  packed word
err_chan  out  1  sticky: channel changed mid-word
words_written  out  16  saturating count of FIFO writes

Behaviour:
- Word format:
  - [139:136] = number of valid beats, 1..8.
  - [135:128] = channel.
  - [127:0] = payload, beat k at [16k+15:16k]; unfilled beats are 0.
- Reset (async, any time, including mid-word):
  - Accumulator, beat count, idle timer, output register, err_chan and words_written all go to 0.
  - fifo_w_enable=0, data_to_fifo=0.
  - A partial word is discarded.
- Output register:
  - Holds out_valid and out_word.
  - fifo_w_enable = out_valid && !fifo_full (combinational); data_to_fifo = out_word.
  - data_to_fifo is 0 whenever out_valid=0.
  - On a write, out_valid clears unless a new word loads on the same edge.
  - out_free = !out_valid || fifo_w_enable.
- Input handshake:
  - din_ready = !(out_valid && fifo_full); it reads 1 out of reset.
- Accumulator FSM states:
  - ACC_IDLE (cnt=0): an accepted beat stores beat 0, latches din_chan, cnt=1, and moves to ACC_FILL.
  - ACC_FILL: an accepted beat writes slot cnt and increments cnt.
  - Close condition: the accepted beat is the 8th, or din_last=1.
  - On close, the completed word (including that beat) loads the output register on the same edge, and the FSM returns to ACC_IDLE.
  - Close in ACC_IDLE with din_last: a 1-beat word.
  - Loading is legal because din_ready=1 implies out_free.
- Latency: fifo_w_enable rises in the cycle after the closing edge (when fifo_full=0). Sustained throughput is 1 beat/cycle with no bubbles at word boundaries.
- Idle timeout:
  - In ACC_FILL, idle_cnt increments on each cycle with no accepted beat, and clears on any acceptance.
  - When idle_cnt reaches TIMEOUT-1 and the cycle is idle, the partial word closes on that edge, provided out_free.
  - If not out_free, the close is held until out_free; idle_cnt saturates.
  - A beat accepted in the expiry cycle wins: it is appended and the timer clears.
- err_chan: set when an accepted non-first beat has din_chan != latched channel. The beat is still packed under the latched channel. Cleared only by reset.
- words_written: +1 per fifo_w_enable cycle, saturating at 0xFFFF.

Decomposition:
- Shared package fifo_pkg:
  - Constants: WORD_W=140, BEAT_W, BEATS, CHAN_W, CNTF_W=4.
  - Field offset constants: CNT_LSB=136, CHAN_LSB=128.
  - Packed struct typedef fifo_word_t {cnt, chan, payload}.
  - Enum acc_state_e {ACC_IDLE, ACC_FILL}.
- One natural sub-module: fifo_out_reg, the one-entry output holding register with the fifo_full handshake. Everything else lives in the top module.

Test Plan:
1. 8 beats 0x0001..0x0008, chan 0x5A, fifo_full=0 -> one write, one cycle after the 8th acceptance. data_to_fifo = {4'h8, 8'h5A, 0x0008_0007_0006_0005_0004_0003_0002_0001}; words_written=1.
2. 3 beats 0xA1,0xA2,0xA3, last on the 3rd, chan 0x03 -> {4'h3, 8'h03, 80'h0, 0x00A3_00A2_00A1}.
3. Word pending with fifo_full=1 for 10 cycles -> din_ready=0, fifo_w_enable=0, data_to_fifo stable. When fifo_full drops, the write occurs in that same cycle and din_ready returns to 1.
4. 2 beats 0x1111,0x2222 then idle -> close on the 64th idle cycle, write the following cycle, count=2. Repeat with a beat arriving in the expiry cycle -> no close; the word continues with 3 beats.
5. Beats on chan 0x10, 0x10, 0x11 -> err_chan=1 from the cycle after the 3rd acceptance, and it stays set. The word channel is 0x10.
6. rst_n asserted after 5 beats -> all outputs 0 immediately. After release, 8 new beats produce one clean word with count 8 and no residue.
